// File: rtl/serial_feeder.sv
// rtl/serial_feeder.sv - parallel word to LSB-first serial din/cen feeder with one-word hold buffer
// Optional build macro: SERIAL_FEEDER_PARITY_EN (appends an even-parity bit after the MSB)
module serial_feeder #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             din,
  output logic             cen,
  output logic             busy
);

`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full, hold_full_n;
  logic [NBITS-1:0] shreg, load_word;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic             accept, reload, last_bit, last_gap, cen_n;

`ifdef SERIAL_FEEDER_PARITY_EN
  assign load_word = {^hold_data, hold_data};
`else
  assign load_word = hold_data;
`endif

  // Gated by resetn so the port reads 0 while the block is held in reset.
  assign in_ready = resetn && !hold_full && !abort;
  assign accept   = in_valid && in_ready;
  assign last_bit = (bit_cnt == CW'(NBITS - 1));
  assign last_gap = (gap_cnt == 4'(GAP - 1));

  always_comb begin
    state_n = state;
    reload  = 1'b0;
    cen_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (hold_full) begin
          reload  = 1'b1;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cen_n = 1'b1;
        if (last_bit) begin
          if (GAP > 0)        state_n = S_GAP;
          else if (hold_full) reload  = 1'b1;
          else                state_n = S_IDLE;
        end
      end
      S_GAP: begin
        if (last_gap) begin
          if (hold_full) begin
            reload  = 1'b1;
            state_n = S_SHIFT;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (abort) begin
      state_n = S_IDLE;
      reload  = 1'b0;
      cen_n   = 1'b0;
    end
    hold_full_n = abort ? 1'b0 : accept ? 1'b1 : reload ? 1'b0 : hold_full;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      din       <= 1'b0;
      cen       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      hold_full <= hold_full_n;
      cen       <= cen_n;
      // Busy stays up through the cycle that presents the final serial bit.
      busy      <= (state_n != S_IDLE) || hold_full_n || cen_n;
      if (accept) hold_data <= in_data;
      if (abort) begin
        shreg   <= '0;
        bit_cnt <= '0;
        gap_cnt <= '0;
        din     <= 1'b0;
      end else begin
        din <= cen_n ? shreg[0] : 1'b0;
        if (reload) begin
          shreg   <= load_word;
          bit_cnt <= '0;
          gap_cnt <= '0;
        end else if (state == S_SHIFT) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + CW'(1);
          gap_cnt <= '0;
        end else if (state == S_GAP) begin
          gap_cnt <= gap_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_feeder.sv
// tb/tb_serial_feeder.sv - scoreboard bench for serial_feeder (GAP=0 and GAP=3 instances)
module tb_serial_feeder;
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, in_valid, abort, g_in_valid, g_abort;
  logic [7:0] in_data, g_in_data;
  logic       in_ready, din, cen, busy;
  logic       g_in_ready, g_din, g_cen, g_busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_q[$];
  bit g_exp_q[$];
  bit hist[2][512];
  int hlen[2];

  serial_feeder #(.WIDTH(8), .GAP(0)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .din(din), .cen(cen), .busy(busy)
  );

  serial_feeder #(.WIDTH(8), .GAP(3)) dut_g (
    .clk(clk), .resetn(resetn), .in_data(g_in_data), .in_valid(g_in_valid),
    .in_ready(g_in_ready), .abort(g_abort), .din(g_din), .cen(g_cen), .busy(g_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hlen[0] < 512) begin hist[0][hlen[0]] = cen; hlen[0]++; end
    if (cen === 1'b1) begin
      if (exp_q.size() == 0) chk("cen_without_word", cen, 0);
      else                   chk("din_bit", din, exp_q.pop_front());
    end else begin
      chk("din_idle_zero", din, 0);
    end
  end

  always @(negedge clk) begin
    if (hlen[1] < 512) begin hist[1][hlen[1]] = g_cen; hlen[1]++; end
    if (g_cen === 1'b1) begin
      if (g_exp_q.size() == 0) chk("g_cen_without_word", g_cen, 0);
      else                     chk("g_din_bit", g_din, g_exp_q.pop_front());
    end else begin
      chk("g_din_idle_zero", g_din, 0);
    end
  end

  task automatic push_word(input int sel, input logic [7:0] w);
    for (int i = 0; i < 8; i++)
      if (sel == 0) exp_q.push_back(w[i]); else g_exp_q.push_back(w[i]);
`ifdef SERIAL_FEEDER_PARITY_EN
    if (sel == 0) exp_q.push_back(^w); else g_exp_q.push_back(^w);
`endif
  endtask

  task automatic send(input logic [7:0] w, input bit keep);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    push_word(0, w);
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic send_g(input logic [7:0] w, input bit keep);
    int n = 0;
    g_in_data  = w;
    g_in_valid = 1'b1;
    while (!g_in_ready && n < 100) begin @(negedge clk); n++; end
    if (!g_in_ready) chk("g_send_timeout", g_in_ready, 1);
    push_word(1, w);
    @(posedge clk); #1;
    if (!keep) g_in_valid = 1'b0;
  endtask

  task automatic clear_hist();
    hlen[0] = 0;
    hlen[1] = 0;
  endtask

  task automatic analyze(input int sel, output int ones, output int first, output int span);
    int last = -1;
    ones = 0; first = -1;
    for (int i = 0; i < hlen[sel]; i++)
      if (hist[sel][i]) begin
        ones++;
        if (first < 0) first = i;
        last = i;
      end
    span = (first < 0) ? 0 : last - first + 1;
  endtask

  task automatic wait_cen(input int count);
    int seen = 0;
    int n = 0;
    while (seen < count && n < 60) begin
      @(negedge clk); n++;
      if (cen) seen++;
    end
    if (seen < count) chk("wait_cen_timeout", seen, count);
  endtask

  initial begin
    int ones, first, span;
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0;
    g_in_valid = 1'b0; g_in_data = '0; g_abort = 1'b0;
    hlen[0] = 0; hlen[1] = 0;

    // Reset state
    @(negedge clk);
    chk("rst_din", din, 0);
    chk("rst_cen", cen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    #2 resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Single word 8'hA5 and latency
    clear_hist();
    send(8'hA5, 1'b0);
    @(negedge clk);
    chk("lat_cycle0_cen", cen, 0);
    chk("held_busy", busy, 1);
    @(negedge clk);
    chk("lat_cycle1_cen", cen, 0);
    @(negedge clk);
    chk("lat_cycle2_cen", cen, 1);
    chk("lat_bit0", din, 1);
    repeat (15) @(negedge clk);
    analyze(0, ones, first, span);
    chk("a5_cen_count", ones, NB);
    chk("a5_contiguous", span, NB);
    chk("a5_end_cen", cen, 0);
    chk("a5_end_busy", busy, 0);
    chk("a5_sb_empty", exp_q.size(), 0);

    // Back-to-back 8'h0F, 8'hF0
    clear_hist();
    send(8'h0F, 1'b1);
    send(8'hF0, 1'b0);
    @(negedge clk);
    chk("b2b_ready_while_held", in_ready, 0);
    chk("b2b_busy", busy, 1);
    repeat (30) @(negedge clk);
    analyze(0, ones, first, span);
    chk("b2b_cen_count", ones, 2 * NB);
    chk("b2b_contiguous", span, 2 * NB);
    chk("b2b_ready_end", in_ready, 1);
    chk("b2b_sb_empty", exp_q.size(), 0);

    // GAP=3 instance: 8'hFF then 8'h00
    clear_hist();
    send_g(8'hFF, 1'b1);
    send_g(8'h00, 1'b0);
    repeat (40) @(negedge clk);
    analyze(1, ones, first, span);
    chk("gap_cen_count", ones, 2 * NB);
    chk("gap_span", span, 2 * NB + 3);
    chk("gap_last_bit_word0", hist[1][first + NB - 1], 1);
    chk("gap_first_idle", hist[1][first + NB], 0);
    chk("gap_word1_start", hist[1][first + NB + 3], 1);
    chk("gap_sb_empty", g_exp_q.size(), 0);
    chk("gap_busy_end", g_busy, 0);

    // Abort at bit 3 of 8'h3C with 8'h55 held
    clear_hist();
    send(8'h3C, 1'b0);
    send(8'h55, 1'b0);
    wait_cen(4);
    chk("abt_pre_busy", busy, 1);
    chk("abt_pre_ready", in_ready, 0);
    abort = 1'b1;
    #1 chk("abt_ready_low", in_ready, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    clear_hist();
    @(negedge clk);
    chk("abt_cen", cen, 0);
    chk("abt_din", din, 0);
    chk("abt_busy", busy, 0);
    chk("abt_ready", in_ready, 1);
    repeat (30) @(negedge clk);
    analyze(0, ones, first, span);
    chk("abt_no_cen", ones, 0);

    // Abort wins over a simultaneous accept
    clear_hist();
    in_data = 8'hAA; in_valid = 1'b1; abort = 1'b1;
    #1 chk("abt_accept_ready", in_ready, 0);
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    repeat (15) @(negedge clk);
    analyze(0, ones, first, span);
    chk("abt_accept_dropped", ones, 0);
    chk("abt_accept_busy", busy, 0);

    // Asynchronous reset mid-word
    send(8'hC3, 1'b0);
    wait_cen(3);
    #2 resetn = 1'b0;
    #1;
    chk("arst_din", din, 0);
    chk("arst_cen", cen, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", in_ready, 0);
    @(posedge clk); #2;
    exp_q.delete();
    g_exp_q.delete();
    clear_hist();
    @(negedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("arst_first_cycle_ready", in_ready, 1);
    repeat (20) @(negedge clk);
    analyze(0, ones, first, span);
    chk("arst_no_cen", ones, 0);
    chk("arst_busy_after", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
